irs_block_write_sequencer: RTL
==============================

IRS_BLOCK_WRITE_SEQUENCER -- requirements
Module: irs_block_write_sequencer

Interface
REQ-001 SHALL have parameter BLOCK_CYCLES, default 8, clocks per block phase (legal range 4..256).
REQ-002 SHALL have parameter WR_SETUP, default 1, first counter value of a phase with irs_wrstrb_o high (1 <= WR_SETUP <= BLOCK_CYCLES-2).
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-004 SHALL have port rst_n_i, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port blk_rst_i, input, 1 bit: synchronous sequencer reset from the block manager.
REQ-006 SHALL have port blk_en_i, input, 1 bit: block offered for the next phase.
REQ-007 SHALL have port blk_i, input, 9 bits: offered block address.
REQ-008 SHALL have port blk_phase_o, output, 1 bit: current write phase.
REQ-009 SHALL have port blk_ack_o, output, 1 bit: one-cycle pulse, block accepted and now being written.
REQ-010 SHALL have port irs_wr_o, output, 9 bits: IRS write block address.
REQ-011 SHALL have port irs_wrstrb_o, output, 1 bit: IRS write strobe.
REQ-012 SHALL have port busy_o, output, 1 bit: a block write is active in the current phase.
REQ-013 SHALL have port phase_err_o, output, 1 bit: sticky flag, a block was offered with the wrong LSB.
REQ-014 SHALL have port blocks_written_o, output, 16 bits: count of acknowledged blocks.

Function
REQ-015 SHALL keep phase counter cnt, 0..BLOCK_CYCLES-1, incrementing every clock while state is not IDLE; on wrap to 0 blk_phase_o SHALL toggle.
REQ-016 SHALL implement states IDLE (blk_rst_i high), SYNC (first full phase after release, no latching allowed), RUN.
REQ-017 SHALL transition IDLE->SYNC on the first clock with blk_rst_i low, SYNC->RUN on the first wrap, and any state->IDLE on the clock after blk_rst_i is sampled high.
REQ-018 In IDLE: cnt=0, blk_phase_o=0, busy_o=0, irs_wrstrb_o=0, no ack.
REQ-019 In RUN at cnt==BLOCK_CYCLES-1 with blk_en_i=1 and blk_i[0] != blk_phase_o: SHALL latch blk_i into irs_wr_o; in the next cycle (cnt=0, phase toggled, blk_phase_o==irs_wr_o[0]) assert blk_ack_o for exactly one cycle and busy_o for the whole phase.
REQ-020 Same condition with blk_i[0] == blk_phase_o: SHALL not latch, not ack, set phase_err_o; the next phase is idle (busy_o=0).
REQ-021 blk_en_i at any cnt other than BLOCK_CYCLES-1 SHALL be ignored.
REQ-022 irs_wrstrb_o SHALL be high exactly in cycles with busy_o=1 and WR_SETUP <= cnt <= BLOCK_CYCLES-2, i.e. registered so it is low at cnt 0 and at cnt BLOCK_CYCLES-1.
REQ-023 irs_wr_o SHALL hold its value until the next latch; it does not change while irs_wrstrb_o is high.
REQ-024 Back-to-back acceptance every phase SHALL be supported with no dead cycles.
REQ-025 blocks_written_o SHALL increment on every blk_ack_o, wrapping 0xFFFF->0x0000.
REQ-026 blk_rst_i asserted mid-write SHALL drop irs_wrstrb_o and busy_o on the next clock; no ack is issued for the aborted block; blocks_written_o SHALL be preserved.
REQ-027 blk_rst_i high SHALL clear phase_err_o; blk_rst_i has priority over a simultaneous latch condition.

Reset
REQ-028 rst_n_i low SHALL immediately force: state IDLE, cnt=0, blk_phase_o=0, blk_ack_o=0, irs_wr_o=0, irs_wrstrb_o=0, busy_o=0, phase_err_o=0, blocks_written_o=0.
REQ-029 Release of rst_n_i SHALL be sampled on clk_i; operation resumes per REQ-017.

Verification
REQ-030 Defaults, release blk_rst_i, hold blk_en_i=0 -> blk_phase_o toggles every 8 clocks starting 0, irs_wrstrb_o never high.
REQ-031 Manager-style stimulus blk_i=0 offered from phase 1 -> latch at cnt=7, phase 0 ack at cnt=0, irs_wr_o=0x000, strobe at cnt 1..6; blk_i=1 next -> ack in phase 1, blocks_written_o=2.
REQ-032 blk_i=0x002 offered at cnt=7 of phase 0 -> no ack, phase_err_o=1, next phase busy_o=0; blk_rst_i pulse -> phase_err_o=0.
REQ-033 blk_rst_i asserted at cnt=3 of an active write -> irs_wrstrb_o low next clock, state IDLE, blk_phase_o=0, blocks_written_o unchanged.
REQ-034 rst_n_i asserted asynchronously mid-strobe -> all outputs at REQ-028 values without waiting for a clock edge.
REQ-035 Continuous offers for 65537 blocks -> blocks_written_o=0x0001, irs_wr_o wraps 0x1FF->0x000 with no missed phase.

Source files
------------

// File: rtl/irs_block_write_sequencer.sv
// IRS block write sequencer: accepts one offered block per write phase and
// drives the IRS write address and strobe for the whole phase.
module irs_block_write_sequencer #(
  parameter int unsigned BLOCK_CYCLES = 8,
  parameter int unsigned WR_SETUP     = 1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        blk_rst_i,
  input  logic        blk_en_i,
  input  logic [8:0]  blk_i,
  output logic        blk_phase_o,
  output logic        blk_ack_o,
  output logic [8:0]  irs_wr_o,
  output logic        irs_wrstrb_o,
  output logic        busy_o,
  output logic        phase_err_o,
  output logic [15:0] blocks_written_o
);

  localparam int unsigned CNT_W  = $clog2(BLOCK_CYCLES);
  localparam int unsigned ADDR_W = 9;
  localparam int unsigned BWC_W  = 16;

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(BLOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] STRB_FIRST = CNT_W'(WR_SETUP);
  localparam logic [CNT_W-1:0] STRB_LAST  = CNT_W'(BLOCK_CYCLES - 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
  logic                phase_d, ack_d, strb_d, busy_d, err_d;
  logic [ADDR_W-1:0]   wr_d;
  logic [BWC_W-1:0]    bwc_d;

  assign cnt_inc = cnt_q + CNT_W'(1);

  // Next-state and next-output logic; blk_rst_i overrides everything else.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phase_d = blk_phase_o;
    ack_d   = 1'b0;
    strb_d  = 1'b0;
    busy_d  = busy_o;
    err_d   = phase_err_o;
    wr_d    = irs_wr_o;
    bwc_d   = blocks_written_o;

    if (blk_rst_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      phase_d = 1'b0;
      busy_d  = 1'b0;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = SYNC;
          cnt_d   = '0;
          phase_d = 1'b0;
          busy_d  = 1'b0;
        end
        SYNC, RUN: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            phase_d = ~blk_phase_o;
            busy_d  = 1'b0;
            if (state_q == SYNC) begin
              state_d = RUN;
            end else if (blk_en_i) begin
              // The accepted block's LSB must match the phase it is written in.
              if (blk_i[0] != blk_phase_o) begin
                wr_d   = blk_i;
                ack_d  = 1'b1;
                busy_d = 1'b1;
                bwc_d  = blocks_written_o + BWC_W'(1);
              end else begin
                err_d = 1'b1;
              end
            end
          end else begin
            cnt_d  = cnt_inc;
            strb_d = busy_o && (cnt_inc >= STRB_FIRST) && (cnt_inc <= STRB_LAST);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          phase_d = 1'b0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      blk_phase_o      <= 1'b0;
      blk_ack_o        <= 1'b0;
      irs_wr_o         <= '0;
      irs_wrstrb_o     <= 1'b0;
      busy_o           <= 1'b0;
      phase_err_o      <= 1'b0;
      blocks_written_o <= '0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      blk_phase_o      <= phase_d;
      blk_ack_o        <= ack_d;
      irs_wr_o         <= wr_d;
      irs_wrstrb_o     <= strb_d;
      busy_o           <= busy_d;
      phase_err_o      <= err_d;
      blocks_written_o <= bwc_d;
    end
  end

endmodule
